tcam_lut_responder: RTL and testbench
=====================================

// Module: tcam_lut_responder
// PURPOSE
//  Lookup-side responder for tcam_lut: accepts one key per request and searches a register-loaded ternary table.
//  Scans ENTRIES_PER_CYCLE entries per clock; lowest matching index wins.
//  Returns hit/index/result to the requester on a valid/ready response port.
//  Sits beside tcam_lut in the user data path.
// PARAMETERS
//  KEY_WIDTH         32  lookup key width in bits
//  RESULT_WIDTH      16  action/result word stored per entry
//  NUM_ENTRIES       16  table depth; power of 2
//  ENTRIES_PER_CYCLE 4   entries compared per SEARCH cycle; power of 2, divides NUM_ENTRIES
//  IDX_W             log2(NUM_ENTRIES), derived with LOG2_FUNC; not overridable
// PORTS
//  clk          in   1             clock
//  reset        in   1             async active-low reset: asserted when 0
//  req_valid    in   1             lookup request present
//  req_key      in   KEY_WIDTH     key to search
//  req_rdy      out  1             responder can accept a request
//  rsp_valid    out  1             response present
//  rsp_hit      out  1             1 = some valid entry matched
//  rsp_index    out  IDX_W         lowest matching index (0 on miss)
//  rsp_result   out  RESULT_WIDTH  result word of matched entry (0 on miss)
//  rsp_rdy      in   1             requester accepts response
//  tbl_wr       in   1             table write strobe
//  tbl_addr     in   IDX_W         entry to write
//  tbl_key      in   KEY_WIDTH     entry key
//  tbl_mask     in   KEY_WIDTH     mask; 1 = don't-care bit
//  tbl_result   in   RESULT_WIDTH  entry result word
//  tbl_valid    in   1             entry valid bit
//  tbl_rdy      out  1             write accepted this cycle
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; all entry valid bits 0; req_rdy=0; rsp_valid=0; rsp_hit=0; rsp_index=0;
//    rsp_result=0; tbl_rdy=0. Key/mask/result storage is not reset.
//  - Match rule: entry e hits iff valid[e] && ((req_key ^ key[e]) & ~mask[e]) == 0.
//  - FSM IDLE -> SEARCH -> RESP -> IDLE.
//    IDLE: req_rdy=1. req_valid&&req_rdy latches req_key, clears hit flag, sets group counter=0, goes to SEARCH.
//    SEARCH: one group of ENTRIES_PER_CYCLE entries per cycle, ascending index. First hit found is recorded; later hits
//    are ignored. Exits after group NUM_ENTRIES/ENTRIES_PER_CYCLE-1 (counter wraps to 0) and goes to RESP.
//    RESP: rsp_valid=1; outputs held stable until rsp_valid&&rsp_rdy, then goes to IDLE.
//  - Latency: request accept edge to rsp_valid = NUM_ENTRIES/ENTRIES_PER_CYCLE + 1 cycles (5 at defaults). Fixed; no early exit.
//  - Throughput: one lookup per latency+1 cycles when rsp_rdy is held 1. req_rdy=0 outside IDLE.
//  - Table writes: tbl_rdy=1 only in IDLE and RESP, so no write can change the table mid-search.
//    The write lands on the edge where tbl_wr&&tbl_rdy. In IDLE, a write and a request on the same edge are both accepted;
//    that search sees the new entry.
//  - tbl_wr while tbl_rdy=0: writer must hold tbl_wr and the tbl_* fields until tbl_rdy=1. No write is lost or duplicated.
//  - Reset mid-search or mid-response: in-flight lookup is discarded; no response is produced.
// CONFIGURATION
//  - TCAM_LUT_RSP_STATS_EN defined: adds outputs stat_hits[31:0] and stat_misses[31:0], both reset to 0.
//    One of them increments on each response handshake. Each saturates at 32'hFFFFFFFF.
//  - TCAM_LUT_RSP_STATS_EN undefined: those ports and counters do not exist. All other behaviour is identical.
// TESTING
//  - Reset, no writes; key 32'h0A000001 -> rsp_hit=0, rsp_index=0, rsp_result=0; rsp_valid 5 cycles after accept.
//  - Entry 3 = key 32'h0A000000, mask 32'h000000FF, result 16'h0042, valid=1; key 32'h0A0000FE -> hit=1, index=3,
//    result=16'h0042. Key 32'h0B000000 -> miss.
//  - Entries 2 and 9 both match key 32'hC0A80101 -> index=2 (priority); invalidate entry 2, repeat -> index=9.
//  - rsp_rdy held 0 for 10 cycles -> rsp_* stable, req_rdy=0. Write issued meanwhile is accepted (tbl_rdy=1 in RESP).
//  - tbl_wr raised during SEARCH -> tbl_rdy=0 until RESP. Current lookup result is unaffected; next lookup sees the entry.
//  - Reset pulsed during SEARCH -> no rsp_valid; all valids 0; with STATS_EN: 3 hits + 2 misses -> stat_hits=3, stat_misses=2.

Source files
------------

// File: rtl/tcam_lut_responder.sv
// Lookup-side responder for tcam_lut: ternary table search, ENTRIES_PER_CYCLE entries per clock.
// Optional: define TCAM_LUT_RSP_STATS_EN to add the stat_hits/stat_misses counters.
package tcam_lut_responder_pkg;
  function automatic int unsigned LOG2_FUNC(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction
endpackage

module tcam_lut_responder
  import tcam_lut_responder_pkg::*;
#(
  parameter int unsigned KEY_WIDTH         = 32,
  parameter int unsigned RESULT_WIDTH      = 16,
  parameter int unsigned NUM_ENTRIES       = 16,
  parameter int unsigned ENTRIES_PER_CYCLE = 4,
  localparam int unsigned IDX_W            = LOG2_FUNC(NUM_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [KEY_WIDTH-1:0]    req_key,
  output logic                    req_rdy,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [IDX_W-1:0]        rsp_index,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  input  logic                    rsp_rdy,
  input  logic                    tbl_wr,
  input  logic [IDX_W-1:0]        tbl_addr,
  input  logic [KEY_WIDTH-1:0]    tbl_key,
  input  logic [KEY_WIDTH-1:0]    tbl_mask,
  input  logic [RESULT_WIDTH-1:0] tbl_result,
  input  logic                    tbl_valid,
  output logic                    tbl_rdy
`ifdef TCAM_LUT_RSP_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int unsigned NUM_GRP = NUM_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int unsigned GRP_W   = (NUM_GRP > 1) ? LOG2_FUNC(NUM_GRP) : 1;
  localparam int unsigned OFF_W   = (ENTRIES_PER_CYCLE > 1) ? LOG2_FUNC(ENTRIES_PER_CYCLE) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_e;

  state_e                  state_q, state_d;
  logic [GRP_W-1:0]        grp_q, grp_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic                    hit_q, hit_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [RESULT_WIDTH-1:0] res_q, res_d;
  logic                    req_rdy_q, req_rdy_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    tbl_rdy_q, tbl_rdy_d;
  logic [NUM_ENTRIES-1:0]  valid_q, valid_d;

  logic [KEY_WIDTH-1:0]    ent_key_q  [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]    ent_mask_q [NUM_ENTRIES];
  logic [RESULT_WIDTH-1:0] ent_res_q  [NUM_ENTRIES];

  logic [KEY_WIDTH-1:0]    cand_key   [ENTRIES_PER_CYCLE];
  logic [KEY_WIDTH-1:0]    cand_mask  [ENTRIES_PER_CYCLE];
  logic [RESULT_WIDTH-1:0] cand_res   [ENTRIES_PER_CYCLE];
  logic [ENTRIES_PER_CYCLE-1:0] cand_valid;

  logic                    grp_hit;
  logic [OFF_W-1:0]        grp_off;
  logic [RESULT_WIDTH-1:0] grp_res;
  logic [IDX_W-1:0]        grp_idx;

  logic req_acc, rsp_acc, wr_en;

  // Only the current group's entries are routed to the comparators.
  always_comb begin
    cand_valid = '0;
    for (int unsigned j = 0; j < ENTRIES_PER_CYCLE; j++) begin
      cand_key[j]  = '0;
      cand_mask[j] = '0;
      cand_res[j]  = '0;
      for (int unsigned g = 0; g < NUM_GRP; g++) begin
        if (grp_q == GRP_W'(g)) begin
          cand_key[j]   = ent_key_q[g*ENTRIES_PER_CYCLE + j];
          cand_mask[j]  = ent_mask_q[g*ENTRIES_PER_CYCLE + j];
          cand_res[j]   = ent_res_q[g*ENTRIES_PER_CYCLE + j];
          cand_valid[j] = valid_q[g*ENTRIES_PER_CYCLE + j];
        end
      end
    end
  end

  always_comb begin
    grp_hit = 1'b0;
    grp_off = '0;
    grp_res = '0;
    for (int unsigned j = 0; j < ENTRIES_PER_CYCLE; j++) begin
      if (!grp_hit && cand_valid[j] &&
          (((key_q ^ cand_key[j]) & ~cand_mask[j]) == '0)) begin
        grp_hit = 1'b1;
        grp_off = OFF_W'(j);
        grp_res = cand_res[j];
      end
    end
    grp_idx = IDX_W'(32'(grp_q) * ENTRIES_PER_CYCLE + 32'(grp_off));
  end

  always_comb begin
    req_acc = (state_q == IDLE) && req_valid && req_rdy_q;
    rsp_acc = (state_q == RESP) && rsp_valid_q && rsp_rdy;
    wr_en   = tbl_wr && tbl_rdy_q;

    state_d = state_q;
    grp_d   = grp_q;
    key_d   = key_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    res_d   = res_q;
    valid_d = valid_q;

    if (wr_en) valid_d[tbl_addr] = tbl_valid;

    case (state_q)
      IDLE: begin
        if (req_acc) begin
          key_d   = req_key;
          hit_d   = 1'b0;
          idx_d   = '0;
          res_d   = '0;
          grp_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (!hit_q && grp_hit) begin
          hit_d = 1'b1;
          idx_d = grp_idx;
          res_d = grp_res;
        end
        if (grp_q == GRP_W'(NUM_GRP - 1)) begin
          grp_d   = '0;
          state_d = RESP;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags track the next state so they are valid on entry to each state.
    req_rdy_d   = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    tbl_rdy_d   = (state_d != SEARCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      key_q       <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      req_rdy_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      tbl_rdy_q   <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      key_q       <= key_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      req_rdy_q   <= req_rdy_d;
      rsp_valid_q <= rsp_valid_d;
      tbl_rdy_q   <= tbl_rdy_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent_key_q[tbl_addr]  <= tbl_key;
      ent_mask_q[tbl_addr] <= tbl_mask;
      ent_res_q[tbl_addr]  <= tbl_result;
    end
  end

  assign req_rdy    = req_rdy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = hit_q;
  assign rsp_index  = idx_q;
  assign rsp_result = res_q;
  assign tbl_rdy    = tbl_rdy_q;

`ifdef TCAM_LUT_RSP_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (rsp_acc) begin
      if (hit_q) begin
        if (stat_hits_q != '1) stat_hits_d = stat_hits_q + 32'd1;
      end else begin
        if (stat_misses_q != '1) stat_misses_d = stat_misses_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_tcam_lut_responder.sv
// Directed self-checking bench for tcam_lut_responder (default parameters).
// Stat counters are checked when TCAM_LUT_RSP_STATS_EN is defined.
module tb_tcam_lut_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_key;
  logic        req_rdy;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [3:0]  rsp_index;
  logic [15:0] rsp_result;
  logic        rsp_rdy;
  logic        tbl_wr;
  logic [3:0]  tbl_addr;
  logic [31:0] tbl_key;
  logic [31:0] tbl_mask;
  logic [15:0] tbl_result;
  logic        tbl_valid;
  logic        tbl_rdy;
`ifdef TCAM_LUT_RSP_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int errors = 0;
  int checks = 0;

  tcam_lut_responder #(
    .KEY_WIDTH(32),
    .RESULT_WIDTH(16),
    .NUM_ENTRIES(16),
    .ENTRIES_PER_CYCLE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_key(req_key),
    .req_rdy(req_rdy),
    .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit),
    .rsp_index(rsp_index),
    .rsp_result(rsp_result),
    .rsp_rdy(rsp_rdy),
    .tbl_wr(tbl_wr),
    .tbl_addr(tbl_addr),
    .tbl_key(tbl_key),
    .tbl_mask(tbl_mask),
    .tbl_result(tbl_result),
    .tbl_valid(tbl_valid),
    .tbl_rdy(tbl_rdy)
`ifdef TCAM_LUT_RSP_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr_entry(input logic [3:0] a, input logic [31:0] k, input logic [31:0] m,
                          input logic [15:0] r, input logic v);
    int n;
    @(negedge clk);
    tbl_wr = 1'b1; tbl_addr = a; tbl_key = k; tbl_mask = m; tbl_result = r; tbl_valid = v;
    n = 0;
    while (!tbl_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tbl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wr_timeout: tbl_rdy=%b required 1", tbl_rdy);
    end
    @(posedge clk);
    #1 tbl_wr = 1'b0;
  endtask

  // lat counts the cycle that starts at the accept edge as cycle 1.
  task automatic start_lookup(input logic [31:0] k, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_key = k;
    n = 0;
    while (!req_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: req_rdy=%b required 1", req_rdy);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] k, output logic h, output logic [3:0] i,
                           output logic [15:0] r, output int lat);
    start_lookup(k, lat);
    h = rsp_hit; i = rsp_index; r = rsp_result;
    finish_rsp();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_key = '0; rsp_rdy = 1'b0;
    tbl_wr = 1'b0; tbl_addr = '0; tbl_key = '0; tbl_mask = '0; tbl_result = '0; tbl_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy: got %b required 0", req_rdy); end
    checks++; if (tbl_rdy !== 1'b0) begin errors++; $display("FAIL rst_tbl_rdy: got %b required 0", tbl_rdy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if ({rsp_hit, rsp_index, rsp_result} !== 21'd0) begin
      errors++; $display("FAIL rst_rsp_fields: hit=%b idx=%0d res=%h required 0/0/0", rsp_hit, rsp_index, rsp_result);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL idle_req_rdy: got %b required 1", req_rdy); end
    checks++; if (tbl_rdy !== 1'b1) begin errors++; $display("FAIL idle_tbl_rdy: got %b required 1", tbl_rdy); end
`ifdef TCAM_LUT_RSP_STATS_EN
    checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++; $display("FAIL rst_stats: hits=%0d misses=%0d required 0/0", stat_hits, stat_misses);
    end
`endif
  endtask

  task automatic test_empty_miss();
    logic h; logic [3:0] i; logic [15:0] r; int lat;
    do_lookup(32'h0A000001, h, i, r, lat);
    checks++; if ({h, i, r} !== 21'd0) begin
      errors++; $display("FAIL empty_miss: hit=%b idx=%0d res=%h required 0/0/0000", h, i, r);
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL empty_latency: got %0d required 5", lat); end
  endtask

  task automatic test_ternary();
    logic h; logic [3:0] i; logic [15:0] r; int lat;
    wr_entry(4'd3, 32'h0A000000, 32'h000000FF, 16'h0042, 1'b1);
    do_lookup(32'h0A0000FE, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd3, 16'h0042}) begin
      errors++; $display("FAIL tern_hit: hit=%b idx=%0d res=%h required 1/3/0042", h, i, r);
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL tern_latency: got %0d required 5", lat); end
    do_lookup(32'h0B000000, h, i, r, lat);
    checks++; if ({h, i, r} !== 21'd0) begin
      errors++; $display("FAIL tern_miss: hit=%b idx=%0d res=%h required 0/0/0000", h, i, r);
    end
    do_lookup(32'h0A000100, h, i, r, lat);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL tern_care_bit: hit=%b required 0", h); end
  endtask

  task automatic test_priority();
    logic h; logic [3:0] i; logic [15:0] r; int lat;
    wr_entry(4'd2, 32'hC0A80101, 32'h00000000, 16'h1111, 1'b1);
    wr_entry(4'd9, 32'hC0A80100, 32'h000000FF, 16'h2222, 1'b1);
    do_lookup(32'hC0A80101, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd2, 16'h1111}) begin
      errors++; $display("FAIL prio_low: hit=%b idx=%0d res=%h required 1/2/1111", h, i, r);
    end
    wr_entry(4'd2, 32'hC0A80101, 32'h00000000, 16'h1111, 1'b0);
    do_lookup(32'hC0A80101, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd9, 16'h2222}) begin
      errors++; $display("FAIL prio_after_inval: hit=%b idx=%0d res=%h required 1/9/2222", h, i, r);
    end
    wr_entry(4'd15, 32'h12345678, 32'h00000000, 16'hF00F, 1'b1);
    do_lookup(32'h12345678, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd15, 16'hF00F}) begin
      errors++; $display("FAIL last_entry: hit=%b idx=%0d res=%h required 1/15/F00F", h, i, r);
    end
  endtask

  task automatic test_backpressure();
    logic h; logic [3:0] i; logic [15:0] r; int lat; int bad;
    start_lookup(32'hC0A80155, lat);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_index !== 4'd9 ||
          rsp_result !== 16'h2222 || req_rdy !== 1'b0) bad++;
      if (k == 2) begin
        checks++; if (tbl_rdy !== 1'b1) begin errors++; $display("FAIL resp_tbl_rdy: got %b required 1", tbl_rdy); end
        tbl_wr = 1'b1; tbl_addr = 4'd5; tbl_key = 32'hAABBCCDD; tbl_mask = '0;
        tbl_result = 16'h5555; tbl_valid = 1'b1;
      end
      if (k == 3) tbl_wr = 1'b0;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: unstable cycles=%0d required 0", bad); end
    finish_rsp();
    do_lookup(32'hAABBCCDD, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd5, 16'h5555}) begin
      errors++; $display("FAIL resp_write: hit=%b idx=%0d res=%h required 1/5/5555", h, i, r);
    end
  endtask

  task automatic test_write_during_search();
    logic h; logic [3:0] i; logic [15:0] r; int lat; int zeros;
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'h66666666;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tbl_wr = 1'b1; tbl_addr = 4'd6; tbl_key = 32'h66666666; tbl_mask = '0;
    tbl_result = 16'h6666; tbl_valid = 1'b1;
    zeros = 0;
    while (tbl_rdy !== 1'b1 && zeros < 20) begin
      zeros++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 tbl_wr = 1'b0;
    checks++; if (zeros !== 4) begin errors++; $display("FAIL search_tbl_rdy_low: cycles=%0d required 4", zeros); end
    checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0) begin
      errors++; $display("FAIL search_unaffected: valid=%b hit=%b required 1/0", rsp_valid, rsp_hit);
    end
    finish_rsp();
    do_lookup(32'h66666666, h, i, r, lat);
    checks++; if ({h, i, r} !== {1'b1, 4'd6, 16'h6666}) begin
      errors++; $display("FAIL search_write_seen: hit=%b idx=%0d res=%h required 1/6/6666", h, i, r);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3]; int n; int rsps; int badidx;
    acc = '{0, 0, 0};
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'h0A0000FE; rsp_rdy = 1'b1;
    n = 0; rsps = 0; badidx = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid === 1'b1) begin rsps++; if (rsp_index !== 4'd3) badidx++; end
      if (req_rdy === 1'b1) begin
        acc[n] = c;
        n++;
        if (n == 3) begin @(posedge clk); #1 req_valid = 1'b0; end
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin rsps++; if (rsp_index !== 4'd3) badidx++; end
      if (req_rdy === 1'b1) break;
    end
    rsp_rdy = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d required 3", n); end
    checks++; if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
      errors++; $display("FAIL b2b_period: got %0d,%0d required 6,6", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++; if (rsps !== 3 || badidx !== 0) begin
      errors++; $display("FAIL b2b_responses: count=%0d bad_idx=%0d required 3/0", rsps, badidx);
    end
  endtask

  task automatic test_reset_mid_search();
    logic h; logic [3:0] i; logic [15:0] r; int lat; int seen;
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'h0A0000FE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_rdy !== 1'b0 || tbl_rdy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: valid=%b req_rdy=%b tbl_rdy=%b required 0/0/0", rsp_valid, req_rdy, tbl_rdy);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: rsp cycles=%0d required 0", seen); end
    do_lookup(32'h0A0000FE, h, i, r, lat);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL midrst_valids_cleared: hit=%b required 0", h); end
    wr_entry(4'd3, 32'h0A000000, 32'h000000FF, 16'h0042, 1'b1);
    for (int k = 0; k < 3; k++) do_lookup(32'h0A0000FE, h, i, r, lat);
    do_lookup(32'h0B000000, h, i, r, lat);
`ifdef TCAM_LUT_RSP_STATS_EN
    checks++; if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      errors++; $display("FAIL stats: hits=%0d misses=%0d required 3/2", stat_hits, stat_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_empty_miss();
    test_ternary();
    test_priority();
    test_backpressure();
    test_write_during_search();
    test_back_to_back();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
